// File: rtl/lcd_msg_arbiter.sv
`default_nettype none
// lcd_msg_arbiter: shares one 2x16 LCD writer between NREQ frame sources with a minimum on-screen hold.
// Define LCD_ARB_RR_EN for round-robin arbitration; the default build is fixed priority (lowest index wins).
module lcd_msg_arbiter #(
    parameter int           NREQ         = 4,
    parameter int           TICK_DIV     = 50000,
    parameter int           MIN_HOLD     = 1000,
    parameter int           LOAD_TIMEOUT = 262144,
    parameter logic [255:0] BOOT_MSG     = {"Loading", {25{8'h20}}}
) (
    input  logic                 disp_clk,
    input  logic                 disp_async_rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*256-1:0]  msg_in,
    output logic [NREQ-1:0]      grant,
    output logic [255:0]         lcd_text,
    output logic                 lcd_load,
    input  logic                 lcd_busy,
    output logic [2:0]           active_id,
    output logic                 active_valid,
    output logic                 err_timeout
);

    localparam int PW = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
    localparam int HW = (MIN_HOLD > 1)     ? $clog2(MIN_HOLD)     : 1;
    localparam int CW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MIN_HOLD - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(LOAD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_IDLE = 3'd1,
        ST_LOAD = 3'd2,
        ST_BUSY = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    state_t          state;
    logic [1:0]      busy_sync;
    logic            busy_s;
    logic [PW-1:0]   pre;
    logic [HW-1:0]   hold;
    logic [CW-1:0]   cnt;
    logic            win_valid;
    logic [2:0]      win_id;
    logic [NREQ-1:0] win_onehot;
    logic [255:0]    win_frame;

    assign busy_s = busy_sync[1];

`ifdef LCD_ARB_RR_EN
    logic [2:0] last_id;
    logic [2:0] any_id;
    logic [2:0] hi_id;
    logic       hi_valid;

    // Prefer the lowest requester above the last grant, else wrap to the lowest overall.
    always_comb begin
        any_id   = 3'd0;
        hi_id    = 3'd0;
        hi_valid = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_id = 3'(i);
                if (i > int'(last_id)) begin
                    hi_id    = 3'(i);
                    hi_valid = 1'b1;
                end
            end
        end
        win_id = hi_valid ? hi_id : any_id;
    end
`else
    always_comb begin
        win_id = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_id = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        win_valid  = |req;
        win_onehot = '0;
        win_frame  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (3'(i) == win_id) begin
                win_onehot[i] = 1'b1;
                win_frame     = msg_in[256*i +: 256];
            end
        end
    end

    always_ff @(posedge disp_clk or negedge disp_async_rst) begin
        if (!disp_async_rst) begin
            state        <= ST_BOOT;
            lcd_text     <= BOOT_MSG;
            lcd_load     <= 1'b0;
            grant        <= '0;
            active_id    <= 3'd0;
            active_valid <= 1'b0;
            err_timeout  <= 1'b0;
            busy_sync    <= 2'b00;
            pre          <= '0;
            hold         <= '0;
            cnt          <= '0;
`ifdef LCD_ARB_RR_EN
            last_id      <= 3'(NREQ - 1);
`endif
        end else begin
            busy_sync <= {busy_sync[0], lcd_busy};
            grant     <= '0;
            case (state)
                ST_BOOT: begin
                    lcd_load <= 1'b1;
                    cnt      <= '0;
                    state    <= ST_LOAD;
                end
                ST_IDLE: begin
                    if (win_valid) begin
                        lcd_text     <= win_frame;
                        grant        <= win_onehot;
                        active_id    <= win_id;
                        active_valid <= 1'b1;
                        lcd_load     <= 1'b1;
                        cnt          <= '0;
                        state        <= ST_LOAD;
`ifdef LCD_ARB_RR_EN
                        last_id      <= win_id;
`endif
                    end
                end
                ST_LOAD: begin
                    if (busy_s) begin
                        lcd_load <= 1'b0;
                        cnt      <= '0;
                        state    <= ST_BUSY;
                    end else if (cnt == CNT_LAST) begin
                        // Give up on this frame but keep serving others.
                        err_timeout <= 1'b1;
                        lcd_load    <= 1'b0;
                        pre         <= '0;
                        hold        <= '0;
                        state       <= ST_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_BUSY: begin
                    if (!busy_s) begin
                        pre   <= '0;
                        hold  <= '0;
                        state <= ST_HOLD;
                    end else if (cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        pre         <= '0;
                        hold        <= '0;
                        state       <= ST_HOLD;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    if (pre == PRE_LAST) begin
                        pre <= '0;
                        if (hold == HOLD_LAST) begin
                            state <= ST_IDLE;
                        end else begin
                            hold <= hold + HW'(1);
                        end
                    end else begin
                        pre <= pre + PW'(1);
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_msg_arbiter.sv
`default_nettype none
// tb_lcd_msg_arbiter: randomized frames/requests checked against a request-level arbitration and timing model.
module tb_lcd_msg_arbiter;

    localparam int NREQ         = 4;
    localparam int TICK_DIV     = 4;
    localparam int MIN_HOLD     = 3;
    localparam int LOAD_TIMEOUT = 16;
    localparam int HOLD_CYC     = MIN_HOLD * TICK_DIV;
    // busy fall -> 2 sync stages -> BUSY exit -> hold -> IDLE grant
    localparam int FALL_GAP     = HOLD_CYC + 4;
    localparam int TO_GAP       = LOAD_TIMEOUT + HOLD_CYC + 1;
    localparam logic [255:0] BOOT = {"Loading", {25{8'h20}}};

    logic                disp_clk = 1'b0;
    logic                disp_async_rst = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*256-1:0] msg_in = '0;
    logic [NREQ-1:0]     grant;
    logic [255:0]        lcd_text;
    logic                lcd_load;
    logic                lcd_busy = 1'b0;
    logic [2:0]          active_id;
    logic                active_valid;
    logic                err_timeout;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    bit           busy_en = 1'b1;
    int           busy_dly = 1;
    int           busy_len = 3;
    int           ref_last = NREQ - 1;
    int           last_grant_cyc = 0;
    logic [255:0] cur_frame = BOOT;
    int           mon_gc;
    bit           mon_ok;
    bit           mon_prev;
    bit           mon_fall;

    lcd_msg_arbiter #(
        .NREQ(NREQ), .TICK_DIV(TICK_DIV), .MIN_HOLD(MIN_HOLD), .LOAD_TIMEOUT(LOAD_TIMEOUT)
    ) dut (
        .disp_clk(disp_clk), .disp_async_rst(disp_async_rst), .req(req), .msg_in(msg_in),
        .grant(grant), .lcd_text(lcd_text), .lcd_load(lcd_load), .lcd_busy(lcd_busy),
        .active_id(active_id), .active_valid(active_valid), .err_timeout(err_timeout)
    );

    always #5 disp_clk = ~disp_clk;
    always @(posedge disp_clk) cyc <= cyc + 1;

    // Writer model: once lcd_load is seen, wait busy_dly cycles, then hold busy for busy_len cycles.
    initial begin
        forever begin
            @(posedge disp_clk);
            #2;
            if (busy_en && lcd_load === 1'b1) begin
                repeat (busy_dly) @(posedge disp_clk);
                #2 lcd_busy = 1'b1;
                repeat (busy_len) @(posedge disp_clk);
                #2 lcd_busy = 1'b0;
            end
        end
    end

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
        logic [NREQ-1:0] t;
`ifdef LCD_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            t = r >> ((last + k) % NREQ);
            if (t[0]) return (last + k) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            t = r >> k;
            if (t[0]) return k;
        end
`endif
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_msg();
        for (int i = 0; i < NREQ * 8; i++) msg_in[32*i +: 32] = $urandom();
    endtask

    task automatic mon_step();
        @(negedge disp_clk);
        if (mon_prev && !lcd_busy) mon_fall = 1'b1;
        mon_prev = lcd_busy;
        if (grant !== '0) mon_gc++;
        if (lcd_text !== cur_frame) mon_ok = 1'b0;
    endtask

    // Wait for the next grant and check it against the model; optional gap checks from busy fall / previous grant.
    task automatic serve(input string tag, input int gap_fall, input int gap_grant);
        int           exp_id;
        int           fall_c;
        int           t0;
        bit           prev_b;
        bit           text_ok;
        bit           got;
        logic [255:0] exp_frame;
        exp_id    = pick(req, ref_last);
        exp_frame = (exp_id >= 0) ? msg_in[256*exp_id +: 256] : '0;
        fall_c    = -1000;
        prev_b    = lcd_busy;
        text_ok   = 1'b1;
        got       = 1'b0;
        t0        = cyc;
        while (!got && (cyc - t0) < 400) begin
            @(negedge disp_clk);
            if (prev_b && !lcd_busy) fall_c = cyc;
            prev_b = lcd_busy;
            if (grant !== '0) got = 1'b1;
            else if (lcd_text !== cur_frame) text_ok = 1'b0;
        end
        chk({tag, " grant"}, grant, 4'b0001 << exp_id);
        chk({tag, " active_id"}, active_id, exp_id);
        chk({tag, " active_valid"}, active_valid, 1);
        chk({tag, " lcd_text"}, lcd_text, exp_frame);
        chk({tag, " lcd_load"}, lcd_load, 1);
        chk({tag, " text held"}, text_ok, 1);
        if (gap_fall >= 0) chk({tag, " busyfall->grant"}, cyc - fall_c, gap_fall);
        if (gap_grant >= 0) chk({tag, " grant->grant"}, cyc - last_grant_cyc, gap_grant);
        last_grant_cyc = cyc;
        ref_last       = exp_id;
        cur_frame      = exp_frame;
    endtask

    initial begin
        int n;
        rand_msg();
        repeat (3) @(negedge disp_clk);
        chk("rst lcd_text", lcd_text, BOOT);
        chk("rst lcd_load", lcd_load, 0);
        chk("rst grant", grant, 0);
        chk("rst active_id", active_id, 0);
        chk("rst active_valid", active_valid, 0);
        chk("rst err_timeout", err_timeout, 0);

        disp_async_rst = 1'b1;
        @(negedge disp_clk);
        chk("boot lcd_load", lcd_load, 1);
        chk("boot lcd_text", lcd_text, BOOT);
        chk("boot active_valid", active_valid, 0);

        req = 4'b1010;
        serve("pri1010", FALL_GAP, -1);
        req = 4'b1000;
        serve("req3", FALL_GAP, -1);
        req = 4'b0000;

        for (int it = 0; it < 10; it++) begin
            req      = req | 4'($urandom_range(1, 15));
            rand_msg();
            busy_dly = $urandom_range(0, 4);
            busy_len = $urandom_range(3, 7);
            serve("rand", FALL_GAP, -1);
            req = req & ~(4'b0001 << ref_last);
        end
        chk("no timeout yet", err_timeout, 0);

        busy_en = 1'b0;
        req     = 4'b0010;
        serve("to_pre", FALL_GAP, -1);
        req = 4'b0100;
        n = 0;
        while (lcd_load === 1'b1 && n < 40) begin
            n++;
            @(negedge disp_clk);
        end
        chk("to lcd_load cycles", n, LOAD_TIMEOUT);
        chk("to err set", err_timeout, 1);
        serve("to_2", -1, TO_GAP);
        busy_en = 1'b1;
        req     = 4'b0001;
        serve("to_rec", FALL_GAP, -1);
        chk("to err sticky", err_timeout, 1);

        req      = 4'b0000;
        mon_gc   = 0;
        mon_ok   = 1'b1;
        mon_prev = lcd_busy;
        mon_fall = 1'b0;
        rand_msg();
        n = 0;
        while (!mon_fall && n < 100) begin
            n++;
            mon_step();
        end
        chk("wd busy fall seen", mon_fall, 1);
        repeat (3) mon_step();
        rand_msg();
        req = 4'b0100;
        repeat (2) mon_step();
        req = 4'b0000;
        repeat (20) mon_step();
        chk("wd no grant", mon_gc, 0);
        chk("wd text held", mon_ok, 1);

        busy_len = 12;
        busy_dly = 1;
        req      = 4'b0001;
        serve("pre_rst", -1, -1);
        n = 0;
        while (lcd_load === 1'b1 && n < 40) begin
            n++;
            @(negedge disp_clk);
        end
        repeat (2) @(negedge disp_clk);
        chk("mid busy seen", lcd_busy, 1);
        disp_async_rst = 1'b0;
        #1;
        chk("arst lcd_load", lcd_load, 0);
        chk("arst grant", grant, 0);
        chk("arst active_valid", active_valid, 0);
        chk("arst active_id", active_id, 0);
        chk("arst err_timeout", err_timeout, 0);
        chk("arst lcd_text", lcd_text, BOOT);
        req = 4'b0000;
        n = 0;
        while (lcd_busy === 1'b1 && n < 40) begin
            n++;
            @(negedge disp_clk);
        end
        repeat (2) @(negedge disp_clk);
        disp_async_rst = 1'b1;
        ref_last  = NREQ - 1;
        cur_frame = BOOT;
        busy_len  = 4;
        @(negedge disp_clk);
        chk("reboot lcd_load", lcd_load, 1);
        chk("reboot lcd_text", lcd_text, BOOT);

        req = 4'b1111;
        rand_msg();
        for (int k = 0; k < 5; k++) begin
            serve("all_req", FALL_GAP, -1);
        end
        req = 4'b0000;
        repeat (40) @(negedge disp_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
